// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display.
// Inputs are snapshotted once per frame; all outputs are registered and active-low.
module seg7_scan_driver #(
  parameter int DIGIT_TICKS  = 100_000,
  parameter int BLANK_TICKS  = 1_000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] seg_data,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int TW = $clog2(DIGIT_TICKS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] BLANK_END = TW'(BLANK_TICKS);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic          running_reg;
  logic [TW-1:0] tick_reg, tick_next;
  logic [1:0]    slot_reg, slot_next;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          blink_phase_reg, blink_phase_next;
  logic [19:0]   snap_data_reg;
  logic [3:0]    snap_blink_reg, snap_dp_reg;
  logic [3:0]    an_reg, an_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic          frame_start_reg, frame_start_next;

  logic          tick_wrap;
  logic          frame_end;
  logic [1:0]    digit_idx;
  logic [4:0]    cur_code;
  logic [6:0]    glyph;
  logic          blanked;
  logic [4:0]    code_arr [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_code
    assign code_arr[gi] = snap_data_reg[5*gi +: 5];
  end

  // Counters hold at zero for one cycle after reset so that the first cycle
  // after release is a complete frame boundary with frame_start high.
  always_comb begin
    tick_wrap        = (tick_reg == TICK_MAX);
    tick_next        = (!running_reg || tick_wrap) ? '0 : tick_reg + TW'(1);
    slot_next        = (running_reg && tick_wrap) ? slot_reg + 2'd1 : slot_reg;
    frame_end        = running_reg && tick_wrap && (slot_reg == 2'd3);
    frame_start_next = (tick_next == '0) && (slot_next == 2'd0);
    frame_cnt_next   = frame_cnt_reg;
    blink_phase_next = blink_phase_reg;
    if (frame_end) begin
      if (frame_cnt_reg == FRAME_MAX) begin
        frame_cnt_next   = '0;
        blink_phase_next = ~blink_phase_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + FW'(1);
      end
    end
  end

  always_comb begin
    digit_idx = 2'd3 - slot_reg;
    cur_code  = code_arr[digit_idx];
    case (cur_code)
      5'd0:    glyph = 7'b1000000;
      5'd1:    glyph = 7'b1111001;
      5'd2:    glyph = 7'b0100100;
      5'd3:    glyph = 7'b0110000;
      5'd4:    glyph = 7'b0011001;
      5'd5:    glyph = 7'b0010010;
      5'd6:    glyph = 7'b0000010;
      5'd7:    glyph = 7'b1111000;
      5'd8:    glyph = 7'b0000000;
      5'd9:    glyph = 7'b0010000;
      5'd15:   glyph = 7'b1000001;
      5'd16:   glyph = 7'b0001100;
      5'd17:   glyph = 7'b0100011;
      5'd19:   glyph = 7'b0100001;
      5'd20:   glyph = 7'b0101011;
      default: glyph = 7'b1111111;
    endcase
  end

  always_comb begin
    blanked  = blink_phase_reg && snap_blink_reg[digit_idx];
    seg_next = blanked ? 7'b1111111 : glyph;
    dp_next  = blanked ? 1'b1 : ~snap_dp_reg[digit_idx];
    an_next  = 4'b1111;
    if (tick_reg >= BLANK_END) begin
      an_next[digit_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running_reg     <= 1'b0;
      tick_reg        <= '0;
      slot_reg        <= 2'd0;
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      snap_data_reg   <= {4{5'd31}};
      snap_blink_reg  <= 4'b0000;
      snap_dp_reg     <= 4'b0000;
      an_reg          <= 4'b1111;
      seg_reg         <= 7'b1111111;
      dp_reg          <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      running_reg     <= 1'b1;
      tick_reg        <= tick_next;
      slot_reg        <= slot_next;
      frame_cnt_reg   <= frame_cnt_next;
      blink_phase_reg <= blink_phase_next;
      an_reg          <= an_next;
      seg_reg         <= seg_next;
      dp_reg          <= dp_next;
      frame_start_reg <= frame_start_next;
      if (frame_start_reg) begin
        snap_data_reg  <= seg_data;
        snap_blink_reg <= blink_mask;
        snap_dp_reg    <= dp_mask;
      end
    end
  end

  assign an          = an_reg;
  assign seg         = seg_reg;
  assign dp          = dp_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues one expectation per
// lit digit window, a negedge monitor pops and compares at each window start.
module tb_seg7_scan_driver;

  localparam int DT = 8;
  localparam int BT = 2;
  localparam int BF = 2;

  logic        clk;
  logic        reset;
  logic [19:0] seg_data;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  seg7_scan_driver #(
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_data   (seg_data),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] frame;
    logic [1:0] slot;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct packed {
    logic [19:0] data;
    logic [3:0]  blink;
    logic [3:0]  dpm;
    logic [3:0]  reps;
    logic [27:0] segs;   // expected glyphs, slot 0 (an[3]) in the top 7 bits
  } vec_t;

  exp_t exp_q[$];
  exp_t cur;
  vec_t vecs[6];

  int checks = 0;
  int passes = 0;
  int inv_err = 0;
  int window_err = 0;
  int fidx = 0;
  logic mon_en = 1'b0;
  logic have_cur = 1'b0;
  logic seen_lit = 1'b0;
  int run_len = 0;
  logic [3:0] prev_an = 4'b1111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic wait_fs();
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) found = 1;
    end
    if (found) fidx++;
    else begin
      checks++;
      $display("FAIL wait_frame_start: no pulse within 64 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d windows still pending, expected 0", exp_q.size());
    end
  endtask

  task automatic push_frame(input logic [27:0] segs, input logic [3:0] blink, input logic [3:0] dpm);
    logic phase;
    phase = ((fidx / BF) % 2) == 1;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      int d;
      logic bl;
      d = 3 - k;
      bl = phase && blink[d];
      e.frame = 8'(fidx);
      e.slot = 2'(k);
      e.an = 4'b1111;
      e.an[d] = 1'b0;
      e.seg = bl ? 7'b1111111 : segs[27-7*k -: 7];
      e.dp = bl ? 1'b1 : ~dpm[d];
      exp_q.push_back(e);
    end
  endtask

  // Monitor: window-start compare, window stability, and scan invariants.
  always @(negedge clk) begin
    if (!reset) begin
      seen_lit = 1'b0;
      run_len = 0;
      have_cur = 1'b0;
    end else if (an == 4'b1111) begin
      run_len++;
    end else begin
      if ($countones(~an) != 1) inv_err++;
      if (seen_lit && run_len != 0 && run_len != BT) inv_err++;
      if (prev_an == 4'b1111) begin
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_window: an=%b with no pending expectation", an);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk($sformatf("win_f%0d_s%0d {an,seg,dp}", cur.frame, cur.slot),
                32'({an, seg, dp}), 32'({cur.an, cur.seg, cur.dp}));
          end
        end else begin
          have_cur = 1'b0;
        end
      end else if (mon_en && have_cur && {an, seg, dp} !== {cur.an, cur.seg, cur.dp}) begin
        window_err++;
      end
      run_len = 0;
      seen_lit = 1'b1;
    end
    prev_an = an;
  end

  initial begin
    int n;
    vecs[0] = '{data: {5'd1, 5'd1, 5'd1, 5'd1}, blink: 4'b0100, dpm: 4'b0000, reps: 4'd6,
                segs: {7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001}};
    vecs[1] = '{data: {5'd25, 5'd31, 5'd10, 5'd8}, blink: 4'b0000, dpm: 4'b0001, reps: 4'd1,
                segs: {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000000}};
    vecs[2] = '{data: {5'd2, 5'd4, 5'd5, 5'd6}, blink: 4'b0000, dpm: 4'b1010, reps: 4'd1,
                segs: {7'b0100100, 7'b0011001, 7'b0010010, 7'b0000010}};
    vecs[3] = '{data: {5'd7, 5'd20, 5'd12, 5'd15}, blink: 4'b1001, dpm: 4'b1111, reps: 4'd3,
                segs: {7'b1111000, 7'b0101011, 7'b1111111, 7'b1000001}};
    vecs[4] = '{data: {5'd16, 5'd3, 5'd0, 5'd9}, blink: 4'b0010, dpm: 4'b0100, reps: 4'd1,
                segs: {7'b0001100, 7'b0110000, 7'b1000000, 7'b0010000}};
    vecs[5] = '{data: {5'd18, 5'd21, 5'd14, 5'd19}, blink: 4'b0000, dpm: 4'b0000, reps: 4'd1,
                segs: {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100001}};

    reset = 1'b0;
    seg_data = {4{5'd31}};
    blink_mask = 4'b0000;
    dp_mask = 4'b0000;

    // Reset state and first-frame timing
    repeat (5) @(negedge clk);
    chk("reset_an", 32'(an), 32'hf);
    chk("reset_seg", 32'(seg), 32'h7f);
    chk("reset_dp", 32'(dp), 32'h1);
    chk("reset_frame_start", 32'(frame_start), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("c0_frame_start", 32'(frame_start), 32'h1);
    chk("c0_an", 32'(an), 32'hf);
    @(negedge clk);
    chk("c1_frame_start", 32'(frame_start), 32'h0);
    chk("c1_an", 32'(an), 32'hf);
    @(negedge clk);
    chk("c2_an", 32'(an), 32'hf);
    @(negedge clk);
    chk("c3_an", 32'(an), 32'h7);
    fidx = 0;

    // "good" loaded at frame 1; frame_start period measured on the way
    seg_data = {5'd9, 5'd17, 5'd17, 5'd19};
    n = 3;
    begin
      bit found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
        @(negedge clk);
        n++;
        if (frame_start === 1'b1) found = 1;
      end
    end
    chk("frame_start_period", 32'(n), 32'(4 * DT));
    fidx = 1;
    mon_en = 1'b1;
    push_frame({7'b0010000, 7'b0100011, 7'b0100011, 7'b0100001}, 4'b0000, 4'b0000);
    drain();

    // Mid-frame change must not tear the current frame
    wait_fs();
    push_frame({7'b0010000, 7'b0100011, 7'b0100011, 7'b0100001}, 4'b0000, 4'b0000);
    repeat (DT + DT / 2) @(negedge clk);
    seg_data = {5'd0, 5'd3, 5'd15, 5'd16};
    drain();
    wait_fs();
    push_frame({7'b1000000, 7'b0110000, 7'b1000001, 7'b0001100}, 4'b0000, 4'b0000);
    drain();

    // Directed vectors: blink, decimal point, blank codes, remaining glyphs
    for (int v = 0; v < 6; v++) begin
      seg_data = vecs[v].data;
      blink_mask = vecs[v].blink;
      dp_mask = vecs[v].dpm;
      for (int r = 0; r < int'(vecs[v].reps); r++) begin
        wait_fs();
        push_frame(vecs[v].segs, vecs[v].blink, vecs[v].dpm);
        drain();
      end
    end

    // Asynchronous reset in the middle of the slot-2 lit window
    wait_fs();
    mon_en = 1'b0;
    repeat (2 * DT + DT / 2) @(negedge clk);
    chk("pre_reset_an", 32'(an), 32'hd);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_an", 32'(an), 32'hf);
    chk("async_reset_seg", 32'(seg), 32'h7f);
    chk("async_reset_dp", 32'(dp), 32'h1);
    chk("async_reset_frame_start", 32'(frame_start), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("restart_frame_start", 32'(frame_start), 32'h1);
    repeat (3) @(negedge clk);
    chk("restart_an", 32'(an), 32'h7);
    repeat (2 * DT) @(negedge clk);

    chk("scan_invariants", 32'(inv_err), 32'h0);
    chk("window_stability", 32'(window_err), 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
